keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_debounce.sv | 90 +++++++++
 rtl/keypad_scanner.sv | 188 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
//
// Shared definitions for the 4x3 matrix keypad scanner:
//   - NOKEY        : code reported when no single valid digit is pressed
//   - scan_state_e : scan FSM state encoding (COL0 -> COL1 -> COL2 -> EVAL)
//   - KEY_MAP      : key code for every (row, column) position
//   - col_drive_for: active-low column drive pattern for a column index
//
// No ports (package).
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam logic [3:0] NOKEY = 4'd10;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        EVAL = 2'd3
    } scan_state_e;

    // Row-major key map. The '*' and '#' positions are real switches but carry
    // no digit, so they decode as NOKEY.
    localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
        '{4'd1,  4'd2, 4'd3 },
        '{4'd4,  4'd5, 4'd6 },
        '{4'd7,  4'd8, 4'd9 },
        '{NOKEY, 4'd0, NOKEY}
    };

    // One-cold column drive pattern: bit `col` low, the others high.
    function automatic logic [2:0] col_drive_for(input logic [1:0] col);
        logic [2:0] pattern;
        pattern = 3'b111;
        pattern[col] = 1'b0;
        return pattern;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
//
// Frame-level debouncer. Once per scan frame (frame_valid high for one cycle)
// it receives the frame's decoded code. The output key only changes after
// DEBOUNCE_CNT consecutive identical frame codes; press and release are
// treated the same way. key_pulse strobes for one cycle when key goes from
// NOKEY to a digit.
//
// Parameters:
//   DEBOUNCE_CNT : consecutive identical frames needed to change key (>= 1)
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   frame_valid in   one-cycle strobe, frame_code is valid
//   frame_code  in   decoded code of the frame just scanned (0-9 or NOKEY)
//   key         out  debounced key code (0-9 or NOKEY), registered
//   key_pulse   out  one-cycle NOKEY-to-digit strobe, registered
// -----------------------------------------------------------------------------
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_valid,
    input  logic [3:0] frame_code,
    output logic [3:0] key,
    output logic       key_pulse
);

    localparam int             CW      = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CNT);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [3:0]    prev_code_q, prev_code_d;
    logic [CW-1:0] stable_cnt_q, stable_cnt_d;
    logic [3:0]    key_q, key_d;
    logic          key_pulse_q, key_pulse_d;

    // NOTE: every signal assigned in an always_comb gets a default value at the
    // top of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        prev_code_d  = prev_code_q;
        stable_cnt_d = stable_cnt_q;
        key_d        = key_q;
        key_pulse_d  = 1'b0;

        if (frame_valid) begin
            if (frame_code == prev_code_q) begin
                // Saturate so a long hold never wraps back below the threshold.
                if (stable_cnt_q != CNT_MAX) begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                end
            end else begin
                stable_cnt_d = CNT_ONE;
                prev_code_d  = frame_code;
            end

            // Once saturated, key already equals frame_code, so reloading it is
            // harmless and the pulse term below evaluates false.
            if (stable_cnt_d == CNT_MAX) begin
                key_d       = frame_code;
                key_pulse_d = (key_q == NOKEY) && (frame_code != NOKEY);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_code_q  <= NOKEY;
            stable_cnt_q <= '0;
            key_q        <= NOKEY;
            key_pulse_q  <= 1'b0;
        end else begin
            prev_code_q  <= prev_code_d;
            stable_cnt_q <= stable_cnt_d;
            key_q        <= key_d;
            key_pulse_q  <= key_pulse_d;
        end
    end

    assign key       = key_q;
    assign key_pulse = key_pulse_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// 4x3 matrix keypad scanner. Columns are driven low one at a time, each for
// SCAN_DIV cycles; rows are sampled on the last cycle of every column. After
// the third column a one-cycle EVAL state decides the frame code: the mapped
// digit if exactly one key was seen in the whole frame, NOKEY otherwise
// (covers no key, '*', '#', and ghosting from multiple keys). Frame codes are
// then debounced by keypad_debounce. Frame period is 3*SCAN_DIV+1 cycles.
//
// Configuration macro:
//   KEYPAD_SYNC_EN : when defined, row passes through a 2-flop synchronizer
//                    (reset value 4'b1111) before sampling. This delays the
//                    sampled view of row by 2 cycles, so SCAN_DIV >= 3 is
//                    required. When undefined, row is sampled directly.
//
// Parameters:
//   SCAN_DIV     : cycles each column is driven (>= 2; >= 3 with sync)
//   DEBOUNCE_CNT : consecutive identical frames needed to change key (>= 1)
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   row       in   keypad rows, active-low, externally pulled up
//   col_drive out  keypad columns, active-low, exactly one bit low, registered
//   key       out  debounced key code, 0-9 or 10 (NOKEY)
//   key_pulse out  one-cycle strobe on NOKEY-to-digit change
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [2:0] col_drive,
    output logic [3:0] key,
    output logic       key_pulse
);

    localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    // -------------------------------------------------------------------------
    // Row input path
    // -------------------------------------------------------------------------
    logic [3:0] row_s;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] row_meta_q;
    logic [3:0] row_sync_q;

    // Idle rows read high, so the synchronizer resets to "no key".
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    assign row_s = row_sync_q;
`else
    assign row_s = row;
`endif

    // -------------------------------------------------------------------------
    // Scan state
    // -------------------------------------------------------------------------
    scan_state_e   state_q;
    logic [DW-1:0] dwell_q;
    logic [2:0]    col_drive_q;
    logic [1:0]    hit_cnt_q;   // keys seen this frame, saturating at 2
    logic [3:0]    hit_code_q;  // code of the most recently seen key

    logic [1:0]    col_idx;
    logic [2:0]    col_hits;
    logic [3:0]    col_code;
    logic [2:0]    hit_sum;
    logic [1:0]    hit_cnt_d;
    logic [3:0]    hit_code_d;

    // Decode the rows seen on the currently driven column and fold them into
    // the frame's running key count. A count of 2 already means "reject", so
    // the count saturates there instead of growing to 12.
    always_comb begin
        col_idx = 2'd0;
        case (state_q)
            COL1:    col_idx = 2'd1;
            COL2:    col_idx = 2'd2;
            default: col_idx = 2'd0;
        endcase

        col_hits = '0;
        col_code = NOKEY;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_s[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = KEY_MAP[r][col_idx];
            end
        end

        hit_sum    = {1'b0, hit_cnt_q} + col_hits;
        hit_cnt_d  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        // Only matters when the frame ends with exactly one hit, in which case
        // this is the single column that produced it.
        hit_code_d = (col_hits != 3'd0) ? col_code : hit_code_q;
    end

    // Scan FSM. col_drive is registered and always loaded with the pattern of
    // the state being entered, so it never glitches between columns.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= COL0;
            dwell_q     <= '0;
            col_drive_q <= 3'b110;
            hit_cnt_q   <= '0;
            hit_code_q  <= NOKEY;
        end else begin
            case (state_q)
                COL0, COL1, COL2: begin
                    if (dwell_q == DWELL_LAST) begin
                        // Last cycle of the column: sample rows and move on.
                        dwell_q    <= '0;
                        hit_cnt_q  <= hit_cnt_d;
                        hit_code_q <= hit_code_d;
                        if (state_q == COL0) begin
                            state_q     <= COL1;
                            col_drive_q <= col_drive_for(2'd1);
                        end else if (state_q == COL1) begin
                            state_q     <= COL2;
                            col_drive_q <= col_drive_for(2'd2);
                        end else begin
                            // EVAL keeps column 0 driven so exactly one column
                            // is always low.
                            state_q     <= EVAL;
                            col_drive_q <= col_drive_for(2'd0);
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                EVAL: begin
                    // Frame decided this cycle; clear accumulators for the next.
                    state_q     <= COL0;
                    dwell_q     <= '0;
                    col_drive_q <= col_drive_for(2'd0);
                    hit_cnt_q   <= '0;
                    hit_code_q  <= NOKEY;
                end
                default: begin
                    state_q     <= COL0;
                    dwell_q     <= '0;
                    col_drive_q <= col_drive_for(2'd0);
                    hit_cnt_q   <= '0;
                    hit_code_q  <= NOKEY;
                end
            endcase
        end
    end

    assign col_drive = col_drive_q;

    // -------------------------------------------------------------------------
    // Frame decision and debounce
    // -------------------------------------------------------------------------
    logic       frame_valid;
    logic [3:0] frame_code;

    assign frame_valid = (state_q == EVAL);
    assign frame_code  = (hit_cnt_q == 2'd1) ? hit_code_q : NOKEY;

    keypad_debounce #(
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_debounce (
        .clock       (clock),
        .reset       (reset),
        .frame_valid (frame_valid),
        .frame_code  (frame_code),
        .key         (key),
        .key_pulse   (key_pulse)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Drives a modelled 4x3 keypad (a 12-bit "held keys" mask, bit = row*3+col)
// whose rows respond combinationally to col_drive. The reference model works
// per frame: the frame code is the digit of the single held key (or 10), and
// key follows the code once the last DEBOUNCE_CNT frame codes agree.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int FRAME        = 3 * SCAN_DIV + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic [2:0]  col_drive;
    logic [3:0]  key;
    logic        key_pulse;

    logic [11:0] held = '0;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    // Reference model state
    int         hist[$];
    logic [3:0] exp_key   = 4'd10;
    logic       exp_pulse = 1'b0;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .col_drive (col_drive),
        .key       (key),
        .key_pulse (key_pulse)
    );

    always #5 clock = ~clock;

    // Keypad: a held switch connects its row to its column while driven low.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (held[r*3+c] && !col_drive[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Digit printed on the key at position idx (row*3+col); '*' and '#' -> 10.
    function automatic logic [3:0] code_of(input int idx);
        if (idx < 9)   return 4'(idx + 1);
        if (idx == 10) return 4'd0;
        return 4'd10;
    endfunction

    function automatic logic [3:0] frame_code_of(input logic [11:0] m);
        if ($countones(m) != 1) return 4'd10;
        for (int i = 0; i < 12; i++) begin
            if (m[i]) return code_of(i);
        end
        return 4'd10;
    endfunction

    // Expected column pattern for cycle i of a frame.
    function automatic logic [2:0] exp_col(input int i);
        if (i < SCAN_DIV)     return 3'b110;
        if (i < 2 * SCAN_DIV) return 3'b101;
        if (i < 3 * SCAN_DIV) return 3'b011;
        return 3'b110;
    endfunction

    task automatic model_frame(input logic [11:0] m);
        int  fc;
        bit  agree;
        fc = int'(frame_code_of(m));
        hist.push_back(fc);
        if (hist.size() > DEBOUNCE_CNT) void'(hist.pop_front());
        agree = (hist.size() == DEBOUNCE_CNT);
        foreach (hist[i]) if (hist[i] != fc) agree = 1'b0;
        if (agree) begin
            exp_pulse = (exp_key == 4'd10) && (fc != 10);
            exp_key   = 4'(fc);
        end else begin
            exp_pulse = 1'b0;
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_key   = 4'd10;
        exp_pulse = 1'b0;
    endtask

    // One scan frame with mask m held from its first cycle. If rst_at >= 0,
    // reset is asserted at that cycle and the frame is abandoned.
    task automatic run_frame(input logic [11:0] m, input int rst_at);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clock);
            check($sformatf("col_drive f%0d c%0d", frame_no, i), 32'(col_drive), 32'(exp_col(i)));
            check($sformatf("key f%0d c%0d", frame_no, i), 32'(key), 32'(exp_key));
            check($sformatf("key_pulse f%0d c%0d", frame_no, i), 32'(key_pulse),
                  (i == 0) ? 32'(exp_pulse) : 32'd0);
            if (i == 0) held = m;
            if (i == rst_at) begin
                reset = 1'b0;
                model_reset();
                repeat (2) begin
                    @(negedge clock);
                    check("rst col_drive", 32'(col_drive), 32'(3'b110));
                    check("rst key", 32'(key), 32'd10);
                    check("rst key_pulse", 32'(key_pulse), 32'd0);
                end
                @(posedge clock);
                #1 reset = 1'b1;
                frame_no++;
                return;
            end
        end
        model_frame(m);
        frame_no++;
    endtask

    task automatic hold(input logic [11:0] m, input int frames);
        for (int f = 0; f < frames; f++) run_frame(m, -1);
    endtask

    localparam logic [11:0] K1    = 12'b0000_0000_0001;
    localparam logic [11:0] K2    = 12'b0000_0000_0010;
    localparam logic [11:0] K5    = 12'b0000_0001_0000;
    localparam logic [11:0] K8    = 12'b0000_1000_0000;
    localparam logic [11:0] K9    = 12'b0001_0000_0000;
    localparam logic [11:0] KSTAR = 12'b0010_0000_0000;
    localparam logic [11:0] K0    = 12'b0100_0000_0000;

    initial begin
        // Reset state
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("reset col_drive", 32'(col_drive), 32'(3'b110));
            check("reset key", 32'(key), 32'd10);
            check("reset key_pulse", 32'(key_pulse), 32'd0);
        end
        @(posedge clock);
        #1 reset = 1'b1;

        // '5' from the first frame: key=5 after the third EVAL.
        hold(K5, 4);
        check("hold5 key", 32'(key), 32'd5);

        // Release, then alternate press/release: never stable long enough.
        hold('0, 4);
        check("release5 key", 32'(key), 32'd10);
        for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? K5 : '0, -1);
        check("toggle5 key", 32'(key), 32'd10);

        // Ghosted '1'+'2', then '1' alone.
        hold(K1 | K2, 5);
        check("ghost12 key", 32'(key), 32'd10);
        hold(K1, 4);
        check("then1 key", 32'(key), 32'd1);
        hold('0, 4);

        // '8' then '*' alone: '*' is not a digit.
        hold(K8, 4);
        check("hold8 key", 32'(key), 32'd8);
        hold(KSTAR, 4);
        check("star key", 32'(key), 32'd10);

        // Digit to digit without an intermediate NOKEY.
        hold(K8, 4);
        hold(K0, 4);
        check("8to0 key", 32'(key), 32'd0);
        hold('0, 4);

        // '9' for 2 frames, reset mid-COL1, keep holding.
        hold(K9, 2);
        run_frame(K9, SCAN_DIV + 2);
        hold(K9, 3);
        check("post-reset 3fr key", 32'(key), 32'd10);
        hold(K9, 1);
        check("post-reset key", 32'(key), 32'd9);

        // Randomised key sequences.
        for (int n = 0; n < 30; n++) begin
            logic [11:0] m;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 6)       m = 12'(1) << $urandom_range(0, 11);
            else if (sel < 8)  m = '0;
            else if (sel == 8) m = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
            else               m = 12'($urandom);
            hold(m, $urandom_range(1, 5));
        end
        hold('0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
